// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-cycle MULTU/DIVU with private HI/LO and EX-stage stall.
// acc_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
module ex_muldiv (
  input  logic        clk,
  input  logic        clr,
  input  logic        EXmd,
  input  logic [1:0]  EXmdop,
  input  logic [31:0] EXqa,
  input  logic [31:0] EXqb,
  output logic        busy,
  output logic        stall,
  output logic        mdsel,
  output logic [31:0] mdres,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] op_q, hi_q, lo_q;
  logic [63:0] acc_q, acc_d;
  logic [32:0] msum, rem, diff;
  logic        start, rd;
  assign start = EXmd & ~EXmdop[1];
  assign rd    = EXmd & EXmdop[1];
  assign busy  = state_q != IDLE;
  assign stall = busy & (start | rd);
  assign mdsel = rd & ~stall;
  assign mdres = EXmdop[0] ? lo_q : hi_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  // op_q is the multiplicand for MUL and the divisor for DIV
  always_comb begin
    msum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, op_q} : 33'd0);
    rem   = {acc_q[63:32], acc_q[31]};
    diff  = rem - {1'b0, op_q};
    acc_d = (state_q == MUL) ? {msum, acc_q[31:1]} :
            diff[32] ? {rem[31:0], acc_q[30:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 32'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else if (state_q == IDLE) begin
      if (start) begin
        op_q    <= EXmdop[0] ? EXqb : EXqa;
        acc_q   <= {32'd0, EXmdop[0] ? EXqa : EXqb};
        cnt_q   <= 5'd0;
        state_q <= EXmdop[0] ? DIV : MUL;
      end
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        hi_q    <= acc_d[63:32];
        lo_q    <= acc_d[31:0];
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench; reads push expected HI/LO, mdsel cycles pop and compare.
module tb_ex_muldiv;
  logic        clk = 0, clr = 1, EXmd = 0;
  logic [1:0]  EXmdop = 2'b00;
  logic [31:0] EXqa = 0, EXqb = 0;
  logic        busy, stall, mdsel;
  logic [31:0] mdres, hi, lo;
  logic [31:0] hi_m = 0, lo_m = 0;
  logic [31:0] exp_q[$];
  int checks = 0, failures = 0, n;
  ex_muldiv dut (.clk(clk), .clr(clr), .EXmd(EXmd), .EXmdop(EXmdop), .EXqa(EXqa), .EXqb(EXqb),
                 .busy(busy), .stall(stall), .mdsel(mdsel), .mdres(mdres), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (mdsel === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("mdres", mdres, exp_q.pop_front());
    end
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int stalls);
    logic [63:0] p;
    stalls = 0;
    EXmd = 1; EXmdop = op; EXqa = a; EXqb = b;
    if (op[1]) exp_q.push_back(op[0] ? lo_m : hi_m);
    else if (!op[0]) begin
      p = {32'd0, a} * {32'd0, b};
      {hi_m, lo_m} = p;
    end else if (b == 0) begin
      hi_m = a; lo_m = 32'hFFFFFFFF;
    end else begin
      hi_m = a % b; lo_m = a / b;
    end
    forever begin
      @(negedge clk);
      if (!stall) break;
      chk("mdsel_in_stall", mdsel, 0);
      stalls++;
      if (stalls > 100) begin
        chk("stall_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    EXmd = 0;
  endtask
  task automatic wait_idle(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy) begin
      cyc++;
      if (cyc > 100) begin
        chk("busy_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int s, c;
    issue(op, a, b, s);
    chk({tag, "_accept_stall"}, s, 0);
    wait_idle(c);
    chk({tag, "_busy_cycles"}, c, 32);
    chk({tag, "_hi"}, hi, hi_m);
    chk({tag, "_lo"}, lo, lo_m);
  endtask
  initial begin
    int s, c;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); #1;
    clr = 0;
    run(2'b00, 7, 6, "mul7x6");
    chk("mul7x6_lo_const", lo, 42);
    chk("mul7x6_hi_const", hi, 0);
    issue(2'b11, 0, 0, s);
    chk("mflo_idle_stall", s, 0);
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulmax");
    chk("mulmax_hi_const", hi, 32'hFFFFFFFE);
    chk("mulmax_lo_const", lo, 32'h00000001);
    run(2'b01, 100, 7, "div100_7");
    chk("div100_7_lo_const", lo, 14);
    chk("div100_7_hi_const", hi, 2);
    run(2'b01, 5, 0, "div5_0");
    chk("div5_0_lo_const", lo, 32'hFFFFFFFF);
    chk("div5_0_hi_const", hi, 5);
    for (int i = 0; i < 3; i++) run(2'b01, $urandom, $urandom_range(1, 32'hFFFF), "div_rand");
    for (int i = 0; i < 3; i++) run(2'b00, $urandom, $urandom, "mul_rand");
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, s);
    issue(2'b10, 0, 0, s);
    chk("mfhi_stall_cycles", s, 32);
    chk("mfhi_busy_after", busy, 0);
    issue(2'b00, 32'hDEADBEEF, 3, s);
    EXmdop = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alu_busy", busy, 1);
      chk("alu_stall", stall, 0);
    end
    wait_idle(c);
    issue(2'b00, 1000, 1000, s);
    issue(2'b01, 32'hCAFEF00D, 1234, s);
    chk("b2b_div_stall", s, 32);
    @(negedge clk);
    chk("b2b_div_busy", busy, 1);
    wait_idle(c);
    chk("b2b_div_busy_cycles", c, 31);
    chk("b2b_hi", hi, 32'hCAFEF00D % 1234);
    chk("b2b_lo", lo, 32'hCAFEF00D / 1234);
    issue(2'b00, 32'h55555555, 32'h77777777, s);
    repeat (10) @(posedge clk);
    #2 clr = 1;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_hi", hi, 0);
    chk("clr_lo", lo, 0);
    hi_m = 0; lo_m = 0;
    @(posedge clk); #1;
    clr = 0;
    issue(2'b11, 0, 0, s);
    chk("clr_mflo_stall", s, 0);
    @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative unsigned multiply/divide unit in the EX stage; consumes the mul/div fields presented by the ID/EX pipeline register. Runs MULTU/DIVU over 32 cycles into private HI/LO registers while independent instructions keep flowing. Raises a stall when an EX-stage instruction needs HI/LO, or the unit itself, while an operation is in flight. The stall freezes PC, IF/ID and ID/EX and injects a bubble into EX/MEM.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  pipeline clock, rising edge.
- clr  in  1  reset; asynchronous, active-high.
- EXmd  in  1  EX-stage instruction is a mul/div-class op; ignore EXmdop when 0.
- EXmdop  in  2  00 MULTU, 01 DIVU, 10 MFHI, 11 MFLO.
- EXqa  in  32  rs operand (multiplicand / dividend).
- EXqb  in  32  rt operand (multiplier / divisor).
- busy  out  1  operation in flight.
- stall  out  1  freeze request to hazard logic; combinational.
- mdsel  out  1  EX result mux selects mdres this cycle.
- mdres  out  32  HI for MFHI, LO for MFLO; combinational.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV; 5-bit iteration counter cnt.
- start = EXmd & ~EXmdop[1]; rd = EXmd & EXmdop[1].
- stall = busy & (start | rd). When busy=0, stall=0.
- mdsel = rd & ~stall.
- IDLE, start: latch operands, clear accumulator, cnt←0, go to MUL (op 00) or DIV (op 01). busy=1 from the next cycle.
- MUL: shift-add, one multiplier bit per cycle, LSB first; 64-bit accumulator; no sign handling.
- DIV: restoring, one quotient bit per cycle, MSB first; remainder 33 bits wide for the compare/subtract.
- Divide by zero is not trapped. Natural restoring result: lo=0xFFFFFFFF, hi=dividend.
- On the edge where cnt==31: write hi (product[63:32] / remainder) and lo (product[31:0] / quotient), go to IDLE.
- hi and lo change only on that completion edge; they hold their value otherwise, including across reads.
- A start presented while busy is stalled. The same instruction stays in ID/EX and is accepted on the first cycle busy=0. No queueing.
- Reset values: state IDLE, cnt=0, busy=0, hi=0, lo=0, accumulators 0. stall and mdsel follow their equations (busy=0, so stall=0).
- clr mid-operation aborts it: hi/lo return to 0, and the partial result is discarded.

## Timing
- Accept edge E0. Iterations run on edges E1..E32. hi/lo are updated and busy falls on edge E32.
- busy is high for exactly 32 cycles after the accept edge.
- MFHI/MFLO entering EX the cycle after E0: stall=1 for 32 cycles; reads the new value in cycle 33 with mdsel=1.
- Back-to-back MULTU: the second is stalled 32 cycles, then accepted in the cycle busy=0. Its own busy starts one cycle later.
- MFHI/MFLO with busy=0: zero latency; mdres is valid in the same cycle.
- Independent non-md instructions never see stall.

## Test plan
- Reset, then MULTU 7×6 → busy high 32 cycles; then hi=0, lo=42; MFLO returns 42 with mdsel=1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 → lo=14, hi=2. DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- MULTU immediately followed by MFHI in EX → stall=1 for exactly 32 cycles, mdsel=0 throughout; MFHI then reads the product high word. An unrelated ALU op in EX during busy → stall=0.
- MULTU followed by DIVU in consecutive EX cycles → DIVU stalled 32 cycles, then accepted; final hi/lo hold the DIVU result.
- Assert clr at cnt=10 of a MULTU → busy, hi, lo go to 0 immediately (asynchronous); after release, MFLO returns 0 with no stall.
